// File: rtl/mult_sequencer.sv
// ============================================================================
// mult_sequencer
// ----------------------------------------------------------------------------
// Control sequencer for a digit-serial multiplier. An order is accepted in IDLE
// on `start`. It then waits in ARM for the next minor-cycle boundary and walks
// the multiplier digits in RUN, one digit per minor cycle. For every digit the
// sequencer tells the datapath whether to add the multiplicand, subtract it, or
// do nothing. The last digit is the sign digit, which subtracts instead of
// adding. An N-type order (neg_op) swaps add and subtract on every digit.
//
// Optional feature (macro MULT_ROUND_EN):
//   When the macro is defined and round_req was latched with start, one extra
//   rounding minor cycle (state ROUND) follows the sign digit before done.
//   When the macro is undefined, round_req is ignored, round_en is tied low and
//   the ROUND state does not exist.
//
// Ports
//   clk        in   system clock, rising edge active
//   rst_n      in   asynchronous active-low reset
//   start      in   one-clk request to begin an order (accepted only in IDLE)
//   long_op    in   sampled with start: 1 = 35 digits, 0 = 17 digits
//   neg_op     in   sampled with start: 1 = negated product
//   round_req  in   sampled with start: rounding request (MULT_ROUND_EN only)
//   mc_end     in   one-clk minor-cycle boundary strobe
//   mpier_lsb  in   current least-significant multiplier digit
//   busy       out  high in every state except IDLE
//   add_en     out  add multiplicand during the current minor cycle
//   sub_en     out  subtract multiplicand during the current minor cycle
//   shift_en   out  one-clk multiplier shift pulse after each non-sign decision
//   digit_cnt  out  index of the digit being processed
//   round_en   out  rounding add active for the current minor cycle
//   done       out  one-clk completion pulse
// ============================================================================
module mult_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       long_op,
    input  logic       neg_op,
    input  logic       round_req,
    input  logic       mc_end,
    input  logic       mpier_lsb,
    output logic       busy,
    output logic       add_en,
    output logic       sub_en,
    output logic       shift_en,
    output logic [5:0] digit_cnt,
    output logic       round_en,
    output logic       done
);

`ifdef MULT_ROUND_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_ROUND = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2
    } state_t;
`endif

    state_t     state_r;
    logic       long_r;
    logic       neg_r;
`ifdef MULT_ROUND_EN
    logic       round_r;
`else
    logic       unused_round_s;
`endif
    logic [5:0] last_idx_s;
    logic [5:0] next_idx_s;

    // Digit decision: a set digit adds, except the sign digit which subtracts.
    // A negated order swaps the two. Result is {add, sub}, never both high.
    function automatic logic [1:0] decide_digit(input logic bit_v,
                                                input logic sign_v,
                                                input logic neg_v);
        logic swap_v;
        swap_v = sign_v ^ neg_v;
        return {bit_v & ~swap_v, bit_v & swap_v};
    endfunction

    assign last_idx_s = long_r ? 6'd34 : 6'd16;
    assign next_idx_s = digit_cnt + 6'd1;

`ifndef MULT_ROUND_EN
    assign unused_round_s = round_req;
    assign round_en       = 1'b0;
`endif

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            long_r    <= 1'b0;
            neg_r     <= 1'b0;
`ifdef MULT_ROUND_EN
            round_r   <= 1'b0;
            round_en  <= 1'b0;
`endif
            busy      <= 1'b0;
            add_en    <= 1'b0;
            sub_en    <= 1'b0;
            shift_en  <= 1'b0;
            digit_cnt <= 6'd0;
            done      <= 1'b0;
        end else begin
            // Pulse outputs default low and are raised only for one clk.
            shift_en <= 1'b0;
            done     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // mc_end is deliberately not looked at here, so a start that
                    // coincides with a boundary leaves ARM waiting for the next one.
                    if (start) begin
                        long_r  <= long_op;
                        neg_r   <= neg_op;
`ifdef MULT_ROUND_EN
                        round_r <= round_req;
`endif
                        busy    <= 1'b1;
                        state_r <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (mc_end) begin
                        // Digit 0 is never the sign digit (N >= 17), so it always shifts.
                        digit_cnt          <= 6'd0;
                        {add_en, sub_en}   <= decide_digit(mpier_lsb, 1'b0, neg_r);
                        shift_en           <= 1'b1;
                        state_r            <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (mc_end) begin
                        if (digit_cnt == last_idx_s) begin
                            add_en <= 1'b0;
                            sub_en <= 1'b0;
`ifdef MULT_ROUND_EN
                            if (round_r) begin
                                round_en <= 1'b1;
                                state_r  <= ST_ROUND;
                            end else begin
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                state_r <= ST_IDLE;
                            end
`else
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= ST_IDLE;
`endif
                        end else begin
                            digit_cnt        <= next_idx_s;
                            {add_en, sub_en} <= decide_digit(mpier_lsb,
                                                             next_idx_s == last_idx_s,
                                                             neg_r);
                            // No shift after the sign digit: the multiplier is exhausted.
                            shift_en         <= (next_idx_s != last_idx_s);
                        end
                    end
                end
`ifdef MULT_ROUND_EN
                ST_ROUND: begin
                    if (mc_end) begin
                        round_en <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    add_en  <= 1'b0;
                    sub_en  <= 1'b0;
`ifdef MULT_ROUND_EN
                    round_en <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// ============================================================================
// tb_mult_sequencer
// Directed bench for mult_sequencer. Inputs change on the falling clock edge
// and outputs are sampled on the falling edge. Minor cycles are 5 clk long.
// ============================================================================
module tb_mult_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       long_op;
    logic       neg_op;
    logic       round_req;
    logic       mc_end;
    logic       mpier_lsb;
    logic       busy;
    logic       add_en;
    logic       sub_en;
    logic       shift_en;
    logic [5:0] digit_cnt;
    logic       round_en;
    logic       done;

    int total;
    int bad;
    int shift_cnt;
    int done_cnt;
    int hold_err;

    mult_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .long_op   (long_op),
        .neg_op    (neg_op),
        .round_req (round_req),
        .mc_end    (mc_end),
        .mpier_lsb (mpier_lsb),
        .busy      (busy),
        .add_en    (add_en),
        .sub_en    (sub_en),
        .shift_en  (shift_en),
        .digit_cnt (digit_cnt),
        .round_en  (round_en),
        .done      (done)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count shift and done pulses seen on falling edges.
    always @(negedge clk) begin
        if (shift_en === 1'b1) shift_cnt <= shift_cnt + 1;
        if (done === 1'b1)     done_cnt  <= done_cnt + 1;
    end

    // Single comparison point: count it and report a mismatch.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One minor cycle: boundary strobe with the given digit, then four quiet clks.
    // Returns the outputs seen just after the boundary edge and checks add/sub hold.
    task automatic minor(input logic bit_v, input logic inj,
                         output logic a, output logic s, output logic d, output logic r);
        @(negedge clk);
        mpier_lsb = bit_v;
        mc_end    = 1'b1;
        @(negedge clk);
        mc_end = 1'b0;
        a = add_en; s = sub_en; d = done; r = round_en;
        if (a && s) hold_err++;
        for (int i = 0; i < 3; i++) begin
            if (inj && i == 0) begin
                start   = 1'b1;
                long_op = ~long_op;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (add_en !== a || sub_en !== s) hold_err++;
        end
        start = 1'b0;
    endtask

    // Complete order: start, N digit boundaries, final boundary (plus round).
    task automatic run_op(input string tag, input logic lg, input logic ng, input logic rnd,
                          input logic [34:0] dig, input logic [34:0] exp_add,
                          input logic [34:0] exp_sub, input int inj_k,
                          input logic coin, input int prev_cnt);
        int n;
        int sh0;
        int dn0;
        logic [34:0] a_mask;
        logic [34:0] s_mask;
        logic a, s, d, r;
        n = lg ? 35 : 17;
        a_mask = '0;
        s_mask = '0;
        hold_err = 0;
        @(negedge clk);
        sh0 = shift_cnt;
        dn0 = done_cnt;
        start = 1'b1; long_op = lg; neg_op = ng; round_req = rnd;
        mc_end = coin;
        @(negedge clk);
        start = 1'b0; mc_end = 1'b0;
        if (coin) begin
            repeat (2) @(negedge clk);
            check({tag, "_arm_busy"}, {63'd0, busy}, 64'd1);
            check({tag, "_arm_cnt"}, {58'd0, digit_cnt}, prev_cnt);
            check({tag, "_arm_addsub"}, {62'd0, add_en, sub_en}, 64'd0);
        end
        for (int k = 0; k < n; k++) begin
            minor(dig[k], k == inj_k, a, s, d, r);
            a_mask[k] = a;
            s_mask[k] = s;
            if (k == 0) check({tag, "_cnt0"}, {58'd0, digit_cnt}, 64'd0);
        end
        check({tag, "_add"}, {29'd0, a_mask}, {29'd0, exp_add});
        check({tag, "_sub"}, {29'd0, s_mask}, {29'd0, exp_sub});
        check({tag, "_cntlast"}, {58'd0, digit_cnt}, n - 1);
        minor(1'b0, 1'b0, a, s, d, r);
        check({tag, "_fin_addsub"}, {62'd0, a, s}, 64'd0);
`ifdef MULT_ROUND_EN
        if (rnd) begin
            check({tag, "_rnd_on"}, {62'd0, r, d}, 64'd2);
            minor(1'b0, 1'b0, a, s, d, r);
        end
`endif
        check({tag, "_done"}, {62'd0, r, d}, 64'd1);
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
        check({tag, "_cnthold"}, {58'd0, digit_cnt}, n - 1);
        check({tag, "_shifts"}, shift_cnt - sh0, n - 1);
        check({tag, "_donecnt"}, done_cnt - dn0, 64'd1);
        check({tag, "_hold"}, hold_err, 64'd0);
    endtask

    initial begin
        logic a, s, d, r;
        int sh0;
        int dn0;
        total = 0; bad = 0; shift_cnt = 0; done_cnt = 0; hold_err = 0;
        rst_n = 1'b0; start = 1'b0; long_op = 1'b0; neg_op = 1'b0;
        round_req = 1'b0; mc_end = 1'b0; mpier_lsb = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", {busy, add_en, sub_en, shift_en, done, round_en, digit_cnt}, 64'd0);
        rst_n = 1'b1;

        // Short positive: digits 0 and 2 set, sign 0.
        run_op("short", 1'b0, 1'b0, 1'b0, 35'h5, 35'h5, 35'h0, -1, 1'b0, 0);
        // Sign digit set, digits 0 and 3 set.
        run_op("sign", 1'b0, 1'b0, 1'b0, 35'h10009, 35'h9, 35'h10000, -1, 1'b0, 0);
        run_op("signneg", 1'b0, 1'b1, 1'b0, 35'h10009, 35'h10000, 35'h9, -1, 1'b0, 0);
        // Long operation, all digits set.
        run_op("long", 1'b1, 1'b0, 1'b0, 35'h7FFFFFFFF, 35'h3FFFFFFFF, 35'h400000000,
               -1, 1'b0, 0);
        // Start together with mc_end: ARM must wait; digit_cnt still holds 34.
        run_op("coin", 1'b0, 1'b0, 1'b0, 35'h5, 35'h5, 35'h0, -1, 1'b1, 34);
        // Second start (with long_op flipped) during RUN is ignored.
        run_op("inj", 1'b0, 1'b0, 1'b0, 35'h10009, 35'h9, 35'h10000, 5, 1'b0, 0);

        // Reset in RUN at digit 9.
        @(negedge clk);
        start = 1'b1; long_op = 1'b0; neg_op = 1'b0; round_req = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10; k++) minor(1'b1, 1'b0, a, s, d, r);
        check("rst_pre_cnt", {58'd0, digit_cnt}, 64'd9);
        check("rst_pre_add", {63'd0, add_en}, 64'd1);
        sh0 = shift_cnt;
        dn0 = done_cnt;
        @(negedge clk);
        mc_end = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {busy, add_en, sub_en, shift_en, done, round_en, digit_cnt}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mc_end = (i % 5 == 0);
        end
        mc_end = 1'b0;
        check("rst_noshift", shift_cnt - sh0, 64'd0);
        check("rst_nodone", done_cnt - dn0, 64'd0);
        check("rst_held", {busy, add_en, sub_en, shift_en, done, round_en, digit_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("postrst", 1'b0, 1'b0, 1'b0, 35'h5, 35'h5, 35'h0, -1, 1'b0, 0);

        // Rounding request: extra minor cycle only when the feature is built in.
        run_op("round", 1'b0, 1'b0, 1'b1, 35'h5, 35'h5, 35'h0, -1, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, named and fixed as follows.
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  one-clk request to begin a multiply order.
REQ-005 long_op  in  1  sampled with start; 1 selects 35 digits, 0 selects 17 digits.
REQ-006 neg_op  in  1  sampled with start; 1 selects a negated product (N-type order).
REQ-007 round_req  in  1  sampled with start; rounding request, used only under MULT_ROUND_EN.
REQ-008 mc_end  in  1  one-clk strobe marking each minor-cycle boundary; at least 4 clk apart.
REQ-009 mpier_lsb  in  1  current least-significant multiplier digit from the datapath.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 add_en  out  1  add the multiplicand into the partial product during the current minor cycle.
REQ-012 sub_en  out  1  subtract the multiplicand during the current minor cycle.
REQ-013 shift_en  out  1  one-clk pulse that shifts the multiplier register one place.
REQ-014 digit_cnt  out  6  index of the digit being processed.
REQ-015 round_en  out  1  rounding add active for the current minor cycle.
REQ-016 done  out  1  one-clk completion pulse.

Function
REQ-017 The block SHALL implement the states IDLE, ARM, RUN, ROUND and SHALL derive N=35 when long_op is latched high and N=17 otherwise.
REQ-018 In IDLE, start SHALL latch long_op, neg_op and round_req and move to ARM; start in any other state SHALL be ignored.
REQ-019 A start coincident with mc_end in IDLE SHALL NOT consume that boundary; ARM SHALL wait for the next mc_end.
REQ-020 At mc_end in ARM the block SHALL set digit_cnt=0, decide digit 0 and move to RUN.
REQ-021 At each non-final mc_end in RUN (digit_cnt<N-1), digit_cnt SHALL increment and the block SHALL decide the new digit.
REQ-022 Deciding digit k SHALL mean sampling mpier_lsb at that mc_end edge: bit=0 gives add_en=sub_en=0; bit=1 gives add for k<N-1 and subtract for k=N-1 (sign digit); neg_op=1 swaps add and subtract.
REQ-023 add_en and sub_en SHALL be registered, held for the entire minor cycle, and never high together.
REQ-024 shift_en SHALL pulse in the clk after each decision for digits 0..N-2 and SHALL NOT pulse after the sign digit.
REQ-025 At mc_end in RUN with digit_cnt=N-1, add_en and sub_en SHALL clear; the block SHALL then enter ROUND under REQ-033, otherwise pulse done in the next clk and return to IDLE.
REQ-026 A complete operation SHALL occupy exactly N minor cycles in RUN, with N-1 shift_en pulses.
REQ-027 digit_cnt SHALL hold its value in IDLE and after done until the next ARM decision.

Reset
REQ-028 On rst_n low, asynchronously, the state SHALL go to IDLE and all outputs and latched options SHALL go to 0, with busy=0.
REQ-029 A reset mid-operation SHALL abandon the operation without pulsing done, and no shift_en SHALL be emitted after reset asserts.
REQ-030 After rst_n rises, the first start SHALL be accepted normally.

Configuration
REQ-031 The macro MULT_ROUND_EN SHALL compile the ROUND state in or out.
REQ-032 Without MULT_ROUND_EN, round_req SHALL be ignored, round_en SHALL be tied 0, and the ROUND state SHALL NOT exist.
REQ-033 With MULT_ROUND_EN and round_req latched high, at the final mc_end the block SHALL enter ROUND and assert round_en for one minor cycle. At the next mc_end it SHALL clear round_en, pulse done in the next clk and return to IDLE.

Verification
REQ-034 Short positive: long_op=0, neg_op=0, mpier digits 1,0,1,0...0 with sign 0 -> add_en in minor cycles 0 and 2 only, 16 shift_en pulses, done one clk after the 17th mc_end in RUN.
REQ-035 Sign digit: long_op=0, sign digit=1 -> sub_en only in minor cycle 16, with no shift_en after it; the same case with neg_op=1 -> add_en in minor cycle 16 and sub_en in the earlier set-digit cycles.
REQ-036 Long operation: long_op=1, all digits 1 -> add_en in cycles 0-33, sub_en in cycle 34, digit_cnt reaching 34, and 34 shift_en pulses.
REQ-037 Boundary cases: start coincident with mc_end -> ARM waits one further boundary; a second start during RUN -> ignored, with the count unchanged.
REQ-038 Reset in RUN at digit 9 -> all outputs 0 immediately, no done pulse; a following start completes normally.
REQ-039 MULT_ROUND_EN defined with round_req=1 -> round_en for exactly one minor cycle after the sign digit, then done; macro undefined -> round_en stays 0 and done follows the sign digit.
